misr_session: RTL and testbench

Parametrised, multi-input signature compactor with a built-in capture-session controller. It is the successor to the single-input 16-bit MISR used in the BIST/response-compaction path. Each session reloads the seed, compacts a programmed number of valid response words, compares the final signature against an expected value, and reports done/pass. It sits between the scan/response outputs of the circuit under test and the test controller.

---
 rtl/misr_pkg.sv | 14 +
 rtl/misr_core.sv | 43 ++++
 rtl/misr_session.sv | 118 +++++++++++
 tb/tb_misr_session.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// Shared types and default constants for the signature compactor.
// Defaults reproduce the legacy 16-bit single-input MISR.
package misr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } misr_state_t;

    localparam logic [15:0] DEF_POLY = 16'h0071;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;

endpackage

// File: rtl/misr_core.sv
// Signature register with seed load and one compaction step per enabled cycle.
// Latency: sig updates one cycle after load/step; sig_next is combinational.
// Backpressure: none; step is simply not asserted when there is no word.
module misr_core
    import misr_pkg::*;
#(
    parameter int                 WIDTH = 16,
    parameter int                 NIN   = 1,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [NIN-1:0]   inj,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] inj_ext;

    always_comb begin
        inj_ext          = '0;
        inj_ext[NIN-1:0] = inj;
    end

    always_comb begin
        sig_next = (sig << 1) ^ (sig[WIDTH-1] ? POLY : '0) ^ inj_ext;
    end

    // load wins over step so a restart never folds in a stray word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (step) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/misr_session.sv
// Session controller: reload seed, compact `length` valid words, compare to `expected`.
// Latency: 1 cycle per word; done/pass appear on the same edge as the last word.
// Backpressure: none; gaps (in_valid=0) hold state. X-mask port with MISR_MASK_EN.
module misr_session
    import misr_pkg::*;
#(
    parameter int                 WIDTH = 16,
    parameter int                 NIN   = 1,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(DEF_SEED),
    parameter int                 CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [WIDTH-1:0] expected,
    input  logic             in_valid,
    input  logic [NIN-1:0]   in,
`ifdef MISR_MASK_EN
    input  logic [NIN-1:0]   in_mask,
`endif
    output logic [WIDTH-1:0] misr_out,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    misr_state_t      state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic             done_q, done_n;
    logic             pass_q, pass_n;
    logic             load, step;
    logic [NIN-1:0]   inj;
    logic [WIDTH-1:0] sig_next;

`ifdef MISR_MASK_EN
    assign inj = in & ~in_mask;
`else
    assign inj = in;
`endif

    misr_core #(
        .WIDTH (WIDTH),
        .NIN   (NIN),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .inj      (inj),
        .sig      (misr_out),
        .sig_next (sig_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            exp_q   <= exp_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        exp_n   = exp_q;
        done_n  = 1'b0;
        pass_n  = pass_q;
        load    = 1'b0;
        step    = 1'b0;
        if (start) begin
            load  = 1'b1;
            cnt_n = length;
            exp_n = expected;
            if (length == '0) begin
                state_n = S_DONE;
                done_n  = 1'b1;
                pass_n  = (SEED == expected);
            end else begin
                state_n = S_RUN;
                pass_n  = 1'b0;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (in_valid) begin
                        step  = 1'b1;
                        cnt_n = cnt_q - 1'b1;
                        // compare against the post-step signature so pass lands with done
                        if (cnt_q == CNT_W'(1)) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                            pass_n  = (sig_next == exp_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_misr_session.sv
// Directed self-checking bench for misr_session with hand-computed signatures.
// Define MISR_MASK_EN at build time to also exercise the X-mask with NIN=4.
module tb_misr_session;

`ifdef MISR_MASK_EN
    localparam int NIN_TB = 4;
`else
    localparam int NIN_TB = 1;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [15:0]       length;
    logic [15:0]       expected;
    logic              in_valid;
    logic [NIN_TB-1:0] in_bits;
`ifdef MISR_MASK_EN
    logic [NIN_TB-1:0] in_mask;
`endif
    logic [15:0]       misr_out;
    logic              busy;
    logic              done;
    logic              pass;

    int errors = 0;
    int checks = 0;

    misr_session #(
        .WIDTH (16),
        .NIN   (NIN_TB),
        .POLY  (16'h0071),
        .SEED  (16'hFFFF),
        .CNT_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .length   (length),
        .expected (expected),
        .in_valid (in_valid),
        .in       (in_bits),
`ifdef MISR_MASK_EN
        .in_mask  (in_mask),
`endif
        .misr_out (misr_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] exp);
        start    = 1'b1;
        length   = len;
        expected = exp;
        tick();
        start    = 1'b0;
    endtask

    task automatic word(input logic [NIN_TB-1:0] d);
        in_valid = 1'b1;
        in_bits  = d;
        tick();
        in_valid = 1'b0;
        in_bits  = '0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        length   = '0;
        expected = '0;
        in_valid = 1'b0;
        in_bits  = '0;
`ifdef MISR_MASK_EN
        in_mask  = '0;
`endif
        #23;
        chk("rst_sig",  misr_out, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        reset = 1'b1;
        tick();

        // single word, in=0
        do_start(16'd1, 16'hFF8F);
        chk("t1_busy", busy, 1);
        chk("t1_seed", misr_out, 16'hFFFF);
        chk("t1_done0", done, 0);
        word('0);
        chk("t1_sig", misr_out, 16'hFF8F);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_busy0", busy, 0);
        gap();
        chk("t1_done_drop", done, 0);
        chk("t1_pass_hold", pass, 1);
        chk("t1_sig_hold", misr_out, 16'hFF8F);
        word('0);
        chk("t1_ignore", misr_out, 16'hFF8F);

        // two words, matching then mismatching expected
        do_start(16'd2, 16'hFF6F);
        chk("t2_pass_clr", pass, 0);
        word('0);
        chk("t2_sig0", misr_out, 16'hFF8F);
        chk("t2_done0", done, 0);
        word('0);
        chk("t2_sig1", misr_out, 16'hFF6F);
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 1);
        do_start(16'd2, 16'hFF6E);
        word('0);
        word('0);
        chk("t2b_sig", misr_out, 16'hFF6F);
        chk("t2b_done", done, 1);
        chk("t2b_pass", pass, 0);

        // single word in=1
        do_start(16'd1, 16'hFF8E);
        word(NIN_TB'(1));
        chk("t3_sig", misr_out, 16'hFF8E);
        chk("t3_pass", pass, 1);

        // gaps between words hold signature and counter
        do_start(16'd3, 16'hFEAD);
        word('0);
        gap();
        gap();
        chk("t3g_hold", misr_out, 16'hFF8F);
        chk("t3g_busy", busy, 1);
        chk("t3g_done0", done, 0);
        word(NIN_TB'(1));
        chk("t3g_sig1", misr_out, 16'hFF6E);
        gap();
        chk("t3g_done1", done, 0);
        word('0);
        chk("t3g_sig2", misr_out, 16'hFEAD);
        chk("t3g_done", done, 1);
        chk("t3g_pass", pass, 1);

        // zero-length session
        do_start(16'd0, 16'hFFFF);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_sig", misr_out, 16'hFFFF);
        chk("t4_pass", pass, 1);
        gap();
        chk("t4_done_drop", done, 0);
        chk("t4_busy2", busy, 0);
        do_start(16'd0, 16'h1234);
        chk("t4b_pass", pass, 0);

        // restart after 3 of 5 words; start beats coincident in_valid
        do_start(16'd5, 16'hFA2F);
        word('0);
        word('0);
        word('0);
        chk("t5_sig3", misr_out, 16'hFEAF);
        in_valid = 1'b1;
        in_bits  = NIN_TB'(1);
        do_start(16'd5, 16'hFA2F);
        in_valid = 1'b0;
        in_bits  = '0;
        chk("t5_restart_sig", misr_out, 16'hFFFF);
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            word('0);
            chk("t5_no_done", done, 0);
        end
        word('0);
        chk("t5_sig", misr_out, 16'hFA2F);
        chk("t5_done", done, 1);
        chk("t5_pass", pass, 1);

        // async reset mid-session
        do_start(16'd5, 16'h0000);
        word('0);
        word('0);
        #2 reset = 1'b0;
        #1;
        chk("t6_sig", misr_out, 16'hFFFF);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_pass", pass, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_idle_busy", busy, 0);

`ifdef MISR_MASK_EN
        in_mask = 4'hF;
        do_start(16'd1, 16'hFF8F);
        word(4'hF);
        chk("t7_mask_all", misr_out, 16'hFF8F);
        chk("t7_pass", pass, 1);
        in_mask = 4'hE;
        do_start(16'd1, 16'hFF8E);
        word(4'hF);
        chk("t7_mask_part", misr_out, 16'hFF8E);
        in_mask = 4'h0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
